// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, fetches from imem and buffers {instr, pc, pc+4} for decode.
// Optional statistics counters enabled with `define FETCH_QUEUE_STATS_EN.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc_plus4,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              stat_fetched,
  output logic [31:0]              stat_flushed
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetchPc;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] countQ;
  logic [31:0]   instrMem   [DEPTH];
  logic [31:0]   pcMem      [DEPTH];
  logic [31:0]   pcPlus4Mem [DEPTH];

  logic pop;
  logic push;

  assign out_valid = (countQ != '0);
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect_valid & ((countQ < DEPTH_C) | pop);

  assign imem_addr    = fetchPc;
  assign count        = countQ;
  assign out_instr    = instrMem[rdPtr];
  assign out_pc       = pcMem[rdPtr];
  assign out_pc_plus4 = pcPlus4Mem[rdPtr];

  // Fetch / enqueue stage: head outputs read registered storage, never imem_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc <= RESET_PC;
      rdPtr   <= '0;
      wrPtr   <= '0;
      countQ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instrMem[i]   <= '0;
        pcMem[i]      <= '0;
        pcPlus4Mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Redirect flushes everything, including a same-edge pop handshake.
      fetchPc <= redirect_pc & ~32'h3;
      rdPtr   <= '0;
      wrPtr   <= '0;
      countQ  <= '0;
    end else begin
      if (push) begin
        instrMem[wrPtr]   <= imem_data;
        pcMem[wrPtr]      <= fetchPc;
        pcPlus4Mem[wrPtr] <= fetchPc + 32'd4;
        wrPtr             <= wrPtr + PW'(1);
        fetchPc           <= fetchPc + 32'd4;
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   countQ <= countQ + CW'(1);
        2'b01:   countQ <= countQ - CW'(1);
        default: countQ <= countQ;
      endcase
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] statFetched;
  logic [31:0] statFlushed;

  function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statFetched <= '0;
      statFlushed <= '0;
    end else begin
      if (push) begin
        statFetched <= satAdd(statFetched, 32'd1);
      end
      if (redirect_valid) begin
        statFlushed <= satAdd(statFlushed, 32'(countQ));
      end
    end
  end

  assign stat_fetched = statFetched;
  assign stat_flushed = statFlushed;
`else
  assign stat_fetched = 32'h0;
  assign stat_flushed = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed vector table, hand sequences, and a randomized queue-model check.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XORK = 32'hA5A5_0000;
`ifdef FETCH_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [$clog2(DEPTH):0] count;
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ XORK;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .count(count),
    .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
  );

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        expValid;
    int          expCount;
    logic [31:0] expAddr;
    logic [31:0] expPc;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(logic r, logic d, logic [31:0] rp, logic v, int c,
                              logic [31:0] a, logic [31:0] p);
    vec_t t;
    t.ready = r; t.redir = d; t.rpc = rp;
    t.expValid = v; t.expCount = c; t.expAddr = a; t.expPc = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic d, input logic [31:0] rp);
    out_ready = r;
    redirect_valid = d;
    redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chkHead(input string name, input logic [31:0] pc);
    chk({name, "_pc"}, out_pc, pc);
    chk({name, "_instr"}, out_instr, pc ^ XORK);
    chk({name, "_pc4"}, out_pc_plus4, pc + 32'd4);
  endtask

  // Behavioural reference: a queue of fetched PCs plus a next-fetch PC.
  logic [31:0] mQ[$];
  logic [31:0] mPc;
  longint      mFetched;
  longint      mFlushed;

  task automatic modelStep(input logic r, input logic d, input logic [31:0] rp);
    bit doPop;
    int sz;
    sz = mQ.size();
    doPop = (sz > 0) && r;
    if (d) begin
      mFlushed += sz;
      mQ.delete();
      mPc = {rp[31:2], 2'b00};
    end else begin
      if (doPop) void'(mQ.pop_front());
      if (sz < DEPTH || doPop) begin
        mQ.push_back(mPc);
        mFetched++;
        mPc = mPc + 32'd4;
      end
    end
  endtask

  initial begin
    vt[0]  = mk(0, 0, 32'h0, 1, 1, 32'd4,  32'h0);
    vt[1]  = mk(0, 0, 32'h0, 1, 2, 32'd8,  32'h0);
    vt[2]  = mk(0, 0, 32'h0, 1, 3, 32'd12, 32'h0);
    vt[3]  = mk(0, 0, 32'h0, 1, 4, 32'd16, 32'h0);
    vt[4]  = mk(0, 0, 32'h0, 1, 4, 32'd16, 32'h0);
    vt[5]  = mk(1, 0, 32'h0, 1, 4, 32'd20, 32'h4);
    vt[6]  = mk(0, 0, 32'h0, 1, 4, 32'd20, 32'h4);
    vt[7]  = mk(0, 1, 32'h0000_0103, 0, 0, 32'h100, 32'h0);
    vt[8]  = mk(0, 0, 32'h0, 1, 1, 32'h104, 32'h100);
    vt[9]  = mk(1, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 32'h0);
    vt[10] = mk(1, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFF8);
    vt[11] = mk(1, 0, 32'h0, 1, 1, 32'h0, 32'hFFFF_FFFC);
    vt[12] = mk(1, 0, 32'h0, 1, 1, 32'h4, 32'h0);

    // Reset state
    doReset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc4", out_pc_plus4, 32'h0);
    chk("rst_fetched", stat_fetched, 32'h0);
    chk("rst_flushed", stat_flushed, 32'h0);

    // Directed table: fill, full hold, full with pop, redirect, wrap
    for (int i = 0; i < 13; i++) begin
      step(vt[i].ready, vt[i].redir, vt[i].rpc);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(vt[i].expValid));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(vt[i].expCount));
      chk($sformatf("tbl%0d_addr", i), imem_addr, vt[i].expAddr);
      if (vt[i].expValid) chkHead($sformatf("tbl%0d", i), vt[i].expPc);
    end

    // Streaming from reset: one entry per cycle, no gaps
    doReset();
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 32'h0);
      chk($sformatf("strm%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("strm%0d_count", k), 32'(count), 32'd1);
      chk($sformatf("strm%0d_pc", k), out_pc, 32'(4 * (k - 1)));
    end

    // Redirect with three entries queued; statistics
    doReset();
    repeat (3) step(0, 0, 32'h0);
    chk("rd3_count_pre", 32'(count), 32'd3);
    step(0, 1, 32'h0000_0103);
    chk("rd3_valid", 32'(out_valid), 32'd0);
    chk("rd3_count", 32'(count), 32'd0);
    chk("rd3_addr", imem_addr, 32'h100);
    step(0, 0, 32'h0);
    chk("rd3_valid2", 32'(out_valid), 32'd1);
    chkHead("rd3_head", 32'h100);
    chk("rd3_flushed", stat_flushed, STATS ? 32'd3 : 32'd0);
    chk("rd3_fetched", stat_fetched, STATS ? 32'd4 : 32'd0);

    // Back-to-back redirects: last wins, no push while held
    step(0, 1, 32'h0000_2000);
    step(0, 1, 32'h0000_3006);
    chk("b2b_count", 32'(count), 32'd0);
    chk("b2b_addr", imem_addr, 32'h3004);
    step(0, 0, 32'h0);
    chkHead("b2b_head", 32'h3004);

    // Asynchronous reset between edges with two entries queued
    doReset();
    repeat (2) step(0, 0, 32'h0);
    chk("ar_count_pre", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_addr", imem_addr, RESET_PC);
    chk("ar_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized run against the queue model
    doReset();
    mQ.delete();
    mPc = RESET_PC;
    mFetched = 0;
    mFlushed = 0;
    for (int n = 0; n < 2000; n++) begin
      logic r, d;
      logic [31:0] rp;
      r  = ($urandom % 4) != 0;
      d  = ($urandom % 16) == 0;
      rp = $urandom;
      modelStep(r, d, rp);
      step(r, d, rp);
      chk("rnd_valid", 32'(out_valid), 32'(mQ.size() > 0));
      chk("rnd_count", 32'(count), 32'(mQ.size()));
      chk("rnd_addr", imem_addr, mPc);
      if (mQ.size() > 0) chkHead("rnd", mQ[0]);
      chk("rnd_fetched", stat_fetched, STATS ? 32'(mFetched) : 32'd0);
      chk("rnd_flushed", stat_flushed, STATS ? 32'(mFlushed) : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
